// File: rtl/alu_bit_serial_seq.sv
// Bit-serial sequencer around a 1-bit logic slice: shifts operands out LSB-first
// under a fixed function select and reassembles the returned bits into a word.
module alu_bit_serial_seq #(
  parameter int WIDTH = 32,
  parameter int CW    = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       le_F,
  output logic             le_a,
  output logic             le_b,
  input  logic             le_x
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sh_a, sh_b;
  logic [3:0]       op_q;
  logic             err_q;

  // Codes 0..6 map onto slice functions; everything above is rejected.
  function automatic logic op_legal(input logic [3:0] f);
    return (f <= 4'd6);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = op_legal(op) ? RUN : DONE;
      RUN:  if (cnt == CW'(WIDTH - 1)) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Capture on accepted start, then one result bit per RUN cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      sh_a   <= '0;
      sh_b   <= '0;
      op_q   <= '0;
      err_q  <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cnt    <= '0;
            result <= '0;
            if (op_legal(op)) begin
              op_q  <= op;
              sh_a  <= src_a;
              sh_b  <= src_b;
              err_q <= 1'b0;
            end else begin
              op_q  <= '0;
              err_q <= 1'b1;
            end
          end
        end
        RUN: begin
          sh_a   <= sh_a >> 1;
          sh_b   <= sh_b >> 1;
          cnt    <= cnt + 1'b1;
          // Bits enter at the MSB so bit k lands at index k after WIDTH shifts.
          result <= {le_x, result[WIDTH-1:1]};
        end
        default: ;
      endcase
    end
  end

  // The slice only sees live values while RUN; idle and done present zeros.
  assign busy = (state != IDLE);
  assign done = (state == DONE);
  assign err  = err_q;
  assign le_F = (state == RUN) ? op_q : 4'd0;
  assign le_a = (state == RUN) & sh_a[0];
  assign le_b = (state == RUN) & sh_b[0];

endmodule
